// File: rtl/alu_core.sv
// alu_core: 32-bit lab CPU ALU with one-hot op strobes and a registered 64-bit result (HI:LO).
// Define ALU_DIV_EN to build the signed divider; otherwise DIV loads zero but keeps its priority slot.
module alu_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        AND,
  input  logic        OR,
  input  logic        ADD,
  input  logic        SUB,
  input  logic        MUL,
  input  logic        DIV,
  input  logic        SHR,
  input  logic        SHL,
  input  logic        ROR,
  input  logic        ROL,
  input  logic        NEG,
  input  logic        NOT,
  input  logic        IncPC,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] C
);

  logic [4:0]  shiftAmount;
  logic [63:0] product;
  logic [63:0] divResult;
  logic [63:0] rorWide;
  logic [63:0] rolWide;
  logic [63:0] nextC;

  assign shiftAmount = B[4:0];

  // Operands are sign-extended to 64 bits so the low 64 bits of the product are the exact signed result.
  assign product = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});

  // Rotates shift a doubled copy of A so the bits falling off one end reappear at the other.
  assign rorWide = {A, A} >> shiftAmount;
  assign rolWide = {A, A} << shiftAmount;

`ifdef ALU_DIV_EN
  logic [31:0] quotient;
  logic [31:0] remainder;

  // Divide-by-zero and the single overflowing case are resolved explicitly rather than left to the operator.
  always_comb begin
    quotient  = 32'h0;
    remainder = 32'h0;
    if (B == 32'h0) begin
      quotient  = 32'hFFFF_FFFF;
      remainder = A;
    end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
      quotient  = 32'h8000_0000;
      remainder = 32'h0;
    end else begin
      quotient  = $signed(A) / $signed(B);
      remainder = $signed(A) % $signed(B);
    end
  end

  assign divResult = {remainder, quotient};
`else
  assign divResult = 64'h0;
`endif

  always_comb begin
    nextC = C;
    if (AND)        nextC = {32'h0, A & B};
    else if (OR)    nextC = {32'h0, A | B};
    else if (ADD)   nextC = {32'h0, A + B};
    else if (SUB)   nextC = {32'h0, A - B};
    else if (MUL)   nextC = product;
    else if (DIV)   nextC = divResult;
    else if (SHR)   nextC = {32'h0, A >> shiftAmount};
    else if (SHL)   nextC = {32'h0, A << shiftAmount};
    else if (ROR)   nextC = {32'h0, rorWide[31:0]};
    else if (ROL)   nextC = {32'h0, rolWide[63:32]};
    else if (NEG)   nextC = {32'h0, 32'h0 - B};
    else if (NOT)   nextC = {32'h0, ~B};
    else if (IncPC) nextC = {32'h0, B + 32'd1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) C <= 64'h0;
    else       C <= nextC;
  end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: scoreboard bench for alu_core; expected results are queued at drive time and checked a cycle later.
// DIV expectations follow ALU_DIV_EN exactly as the design is built.
module tb_alu_core;

  localparam logic [12:0] S_AND   = 13'h1000;
  localparam logic [12:0] S_OR    = 13'h0800;
  localparam logic [12:0] S_ADD   = 13'h0400;
  localparam logic [12:0] S_SUB   = 13'h0200;
  localparam logic [12:0] S_MUL   = 13'h0100;
  localparam logic [12:0] S_DIV   = 13'h0080;
  localparam logic [12:0] S_SHR   = 13'h0040;
  localparam logic [12:0] S_SHL   = 13'h0020;
  localparam logic [12:0] S_ROR   = 13'h0010;
  localparam logic [12:0] S_ROL   = 13'h0008;
  localparam logic [12:0] S_NEG   = 13'h0004;
  localparam logic [12:0] S_NOT   = 13'h0002;
  localparam logic [12:0] S_INCPC = 13'h0001;

  typedef struct {
    string       tag;
    logic [63:0] expected;
  } sbEntry_t;

  logic        clk;
  logic        reset;
  logic [12:0] ops;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] C;

  sbEntry_t    scoreboard[$];
  logic [63:0] lastExpected;
  int          testsRun;
  int          testsFailed;

  alu_core dut (
    .clk   (clk),
    .reset (reset),
    .AND   (ops[12]),
    .OR    (ops[11]),
    .ADD   (ops[10]),
    .SUB   (ops[9]),
    .MUL   (ops[8]),
    .DIV   (ops[7]),
    .SHR   (ops[6]),
    .SHL   (ops[5]),
    .ROR   (ops[4]),
    .ROL   (ops[3]),
    .NEG   (ops[2]),
    .NOT   (ops[1]),
    .IncPC (ops[0]),
    .A     (A),
    .B     (B),
    .C     (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Reference model written from the operation definitions: bit loops for shifts, magnitude arithmetic for DIV.
  function automatic logic [63:0] refModel(input logic [12:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] prev);
    logic [31:0] r;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] q;
    logic [31:0] rem;
    longint      prod;
    int          amt;
    amt = int'(b[4:0]);
    r = a;
    if (op[12]) return {32'h0, a & b};
    if (op[11]) return {32'h0, a | b};
    if (op[10]) return {32'h0, a + b};
    if (op[9])  return {32'h0, a + ~b + 32'd1};
    if (op[8]) begin
      prod = longint'($signed(a)) * longint'($signed(b));
      return prod;
    end
    if (op[7]) begin
`ifdef ALU_DIV_EN
      if (b == 32'h0) return {a, 32'hFFFF_FFFF};
      magA = a[31] ? -a : a;
      magB = b[31] ? -b : b;
      q    = magA / magB;
      rem  = magA % magB;
      if (a[31] != b[31]) q = -q;
      if (a[31]) rem = -rem;
      return {rem, q};
`else
      return 64'h0;
`endif
    end
    if (op[6]) begin
      for (int i = 0; i < amt; i++) r = {1'b0, r[31:1]};
      return {32'h0, r};
    end
    if (op[5]) begin
      for (int i = 0; i < amt; i++) r = {r[30:0], 1'b0};
      return {32'h0, r};
    end
    if (op[4]) begin
      for (int i = 0; i < amt; i++) r = {r[0], r[31:1]};
      return {32'h0, r};
    end
    if (op[3]) begin
      for (int i = 0; i < amt; i++) r = {r[30:0], r[31]};
      return {32'h0, r};
    end
    if (op[2]) return {32'h0, ~b + 32'd1};
    if (op[1]) return {32'h0, ~b};
    if (op[0]) return {32'h0, b + 32'd1};
    return prev;
  endfunction

  task automatic applyStimulus(input string tag, input logic [12:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] expected);
    sbEntry_t entry;
    @(negedge clk);
    ops = op;
    A   = a;
    B   = b;
    entry.tag      = tag;
    entry.expected = expected;
    scoreboard.push_back(entry);
    lastExpected = expected;
  endtask

  task automatic applyModel(input string tag, input logic [12:0] op, input logic [31:0] a,
                            input logic [31:0] b);
    applyStimulus(tag, op, a, b, refModel(op, a, b, lastExpected));
  endtask

  task automatic drainScoreboard();
    int budget;
    budget = 0;
    while (scoreboard.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (scoreboard.size() != 0) begin
      checkOutput("drain_timeout", 64'(scoreboard.size()), 64'h0);
      scoreboard.delete();
    end
  endtask

  // Monitor: one result per clock edge, popped after the edge has settled.
  initial begin
    sbEntry_t entry;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && scoreboard.size() != 0) begin
        entry = scoreboard.pop_front();
        checkOutput(entry.tag, C, entry.expected);
      end
    end
  end

  initial begin
    logic [12:0] rndOp;
    logic [31:0] rndB;
    testsRun     = 0;
    testsFailed  = 0;
    lastExpected = 64'h0;

    reset = 1'b1;
    ops   = S_ADD;
    A     = 32'd3;
    B     = 32'd4;
    #1;
    checkOutput("reset_async", C, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold", C, 64'h0);

    @(negedge clk);
    reset = 1'b0;
    applyStimulus("add_after_reset", S_ADD, 32'd3, 32'd4, 64'h7);

    applyStimulus("and", S_AND, 32'd3, 32'd4, 64'h0);
    applyStimulus("or", S_OR, 32'd3, 32'd4, 64'h7);
    applyStimulus("sub", S_SUB, 32'd3, 32'd4, 64'h0000_0000_FFFF_FFFF);
    applyStimulus("neg", S_NEG, 32'd3, 32'd4, 64'h0000_0000_FFFF_FFFC);
    applyStimulus("not", S_NOT, 32'd3, 32'd4, 64'h0000_0000_FFFF_FFFB);
    applyStimulus("incpc", S_INCPC, 32'd3, 32'd4, 64'h5);

    applyStimulus("mul_neg", S_MUL, 32'hFFFF_FFFD, 32'd4, 64'hFFFF_FFFF_FFFF_FFF4);
    applyStimulus("mul_big", S_MUL, 32'h7FFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFE);

`ifdef ALU_DIV_EN
    applyStimulus("div_neg", S_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus("div_zero", S_DIV, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF);
    applyStimulus("div_ovf", S_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    applyStimulus("div_pos", S_DIV, 32'd100, 32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2);
`else
    applyStimulus("div_disabled", S_DIV, 32'hFFFF_FFF9, 32'd2, 64'h0);
    applyStimulus("mul_before_mask", S_MUL, 32'd5, 32'd5, 64'd25);
    applyStimulus("div_masks_shl", S_DIV | S_SHL, 32'h8000_0001, 32'd1, 64'h0);
`endif

    applyStimulus("shr", S_SHR, 32'h8000_0001, 32'd1, 64'h4000_0000);
    applyStimulus("shl", S_SHL, 32'h8000_0001, 32'd1, 64'h0000_0002);
    applyStimulus("ror", S_ROR, 32'h8000_0001, 32'd1, 64'hC000_0000);
    applyStimulus("rol", S_ROL, 32'h8000_0001, 32'd1, 64'h0000_0003);
    applyStimulus("ror_b33", S_ROR, 32'h8000_0001, 32'd33, 64'hC000_0000);
    applyStimulus("shr_zero", S_SHR, 32'h8000_0001, 32'd32, 64'h8000_0001);

    applyStimulus("prio_and_add", S_AND | S_ADD, 32'd3, 32'd4, 64'h0);
    applyStimulus("set_before_idle", S_ADD, 32'h1234_0000, 32'h0000_5678, 64'h1234_5678);
    repeat (3) applyStimulus("idle_hold", 13'h0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 64'h1234_5678);
    applyStimulus("wrap_add", S_ADD, 32'hFFFF_FFFF, 32'd2, 64'h1);
    applyStimulus("wrap_incpc", S_INCPC, 32'd0, 32'hFFFF_FFFF, 64'h0);

    // Randomised ops, mostly single strobes with occasional collisions to exercise priority.
    for (int i = 0; i < 60; i++) begin
      rndOp = 13'h1 << $urandom_range(12, 0);
      if ($urandom_range(3, 0) == 0) rndOp = rndOp | (13'h1 << $urandom_range(12, 0));
      if ($urandom_range(7, 0) == 0) rndOp = 13'h0;
      rndB = $urandom;
      if ($urandom_range(5, 0) == 0) rndB = 32'(int'($urandom_range(2, 0)) - 1);
      applyModel("random", rndOp, $urandom, rndB);
    end

    drainScoreboard();

    // Reset in the middle of a cycle drops the pending MUL result.
    @(negedge clk);
    ops = S_MUL;
    A   = 32'h0001_0000;
    B   = 32'h0001_0000;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_async", C, 64'h0);
    @(posedge clk);
    #1;
    checkOutput("reset_mid_edge", C, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    ops   = 13'h0;
    lastExpected = 64'h0;
    @(posedge clk);
    #1;
    checkOutput("idle_after_reset", C, 64'h0);
    applyStimulus("mul_after_reset", S_MUL, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);

    drainScoreboard();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
